fpnew_sdotp_arbiter: RTL and testbench
======================================

# fpnew_sdotp_arbiter

Round-robin scheduler that shares a single `fpnew_sdotp_multi_wrapper` instance between `NumReq` independent requesters, e.g. several cores or vector lanes. It grants one request per cycle to the unit and tags each issued operation with the requester index. It limits the number of operations in flight and routes each returning result back to its originating requester by tag. The block sits directly in front of the dot-product unit; the unit's own tag and aux fields carry the requester index.

## Interface
- `NumReq`, 4: number of requesters, ≥2.
- `MaxOutstanding`, 4: maximum issued-but-unreturned operations, ≥1. It must be ≥ unit pipeline depth + 1 for full throughput.
- `ReqType`, logic: request payload (operands, is_boxed, rnd_mode, op, op_mod, src/dst fmt), forwarded untouched.
- `RspType`, logic: response payload (result, status, extension bit), forwarded untouched.
- `IdxWidth` (localparam): `$clog2(NumReq)`.
- `clk_i` in 1: clock.
- `rst_i` in 1: **synchronous, active-high** reset. One clock domain only.
- `req_valid_i` in NumReq: per-requester valid.
- `req_ready_o` out NumReq: per-requester ready. At most one bit is high per cycle.
- `req_i` in NumReq×ReqType: per-requester payload.
- `unit_valid_o` out 1: issue valid to the unit.
- `unit_ready_i` in 1: unit in_ready.
- `unit_req_o` out ReqType: payload of the granted requester.
- `unit_tag_o` out IdxWidth: index of the granted requester.
- `unit_rsp_valid_i` in 1: unit out_valid.
- `unit_rsp_ready_o` out 1: unit out_ready.
- `unit_rsp_i` in RspType: unit result payload.
- `unit_rsp_tag_i` in IdxWidth: returned tag.
- `rsp_valid_o` out NumReq: per-requester response valid.
- `rsp_ready_i` in NumReq: per-requester response ready.
- `rsp_o` out RspType: response payload, broadcast to all requesters.
- `flush_i` in 1: kill everything in flight.
- `flush_o` out 1: flush forwarded to the unit.
- `busy_o` out 1: operations pending or issuing.

## Operation
- **State:**
  - `ptr_q` (IdxWidth): round-robin priority pointer.
  - `cnt_q` (`$clog2(MaxOutstanding+1)` bits): outstanding counter.
  - `lock_q` (1) and `lock_idx_q` (IdxWidth): grant lock.
- **Arbitration:**
  - The winner is the first requester with `req_valid_i` set, searching from `ptr_q` upward and wrapping modulo NumReq.
  - If `lock_q` is set, the winner is forced to `lock_idx_q`.
- **Issue gating:** `unit_valid_o = any valid && cnt_q < MaxOutstanding && !flush_i`. The gate uses the registered `cnt_q` only; a same-cycle response does not bypass it.
- **Handshakes:**
  - `req_ready_o[w] = unit_valid_o && unit_ready_i`. All other ready bits are 0.
  - An issue handshake is `unit_valid_o && unit_ready_i`.
- **Lock state machine (IDLE/LOCKED):**
  - IDLE→LOCKED when `unit_valid_o && !unit_ready_i`; latch the winner into `lock_idx_q`.
  - LOCKED→IDLE on an issue handshake or on `flush_i`.
  - While LOCKED, the payload and tag stay stable. Requesters must keep valid asserted (valid/ready rule).
- **Pointer:** on an issue handshake, `ptr_q <= (winner == NumReq-1) ? 0 : winner+1`. Otherwise it holds.
- **Response routing:**
  - `rsp_valid_o[t] = unit_rsp_valid_i && (unit_rsp_tag_i == t)`.
  - `unit_rsp_ready_o = rsp_ready_i[unit_rsp_tag_i]`.
  - `rsp_o = unit_rsp_i`.
- **Counter:** +1 on an issue handshake, −1 on a response handshake, unchanged when both occur in the same cycle. A response with `cnt_q == 0` is a protocol error; flag it with an assertion and do not let the counter go below zero.
- **Flush:**
  - `flush_o = flush_i`, combinational.
  - On flush: `cnt_q <= 0` and `lock_q <= 0`. `ptr_q` holds.
  - Any handshake in the flush cycle is discarded.
- **busy_o:** `cnt_q != 0 || unit_valid_o`.

## Timing
- The request path (`req_*` → `unit_*`) is combinational, with zero added latency.
- The response path (`unit_rsp_*` → `rsp_*`) is combinational, with zero added latency.
- Sustained throughput is 1 issue/cycle while `cnt_q < MaxOutstanding` and the unit is ready.
- **Counter full:** when `cnt_q == MaxOutstanding`, `unit_valid_o` is 0. Issue resumes in the cycle after the first response handshake.
- **Reset:** `rst_i` high at a rising edge gives `ptr_q=0`, `cnt_q=0`, `lock_q=0`. Consequently:
  - `unit_valid_o`, `req_ready_o` and `busy_o` are 0 in the cycle after reset, unless requests are valid.
  - `rsp_valid_o` follows the unit, which is reset in the same cycle.
  - Reset mid-operation drops all in-flight bookkeeping.

## Structure
- No new package is needed. `IdxWidth` and the counter width are local. The payload types come from the instantiating level, which builds them from `fpnew_pkg` types.
- Sub-module `fpnew_sdotp_rr_picker`: combinational rotate-priority picker (valid vector + pointer → winner index + any-valid). The lock, counter and pointer registers stay in the top level.

## Test plan
- **Single request:** reset, then requester 2 presents one request with the unit ready → `unit_tag_o=2` and `req_ready_o=4'b0100` in the same cycle, `cnt_q` goes to 1. The response with tag 2 raises only `rsp_valid_o[2]`, and `cnt_q` returns to 0.
- **Fairness:** all 4 requesters valid continuously, unit always ready, responses returned 3 cycles later → grant order 0,1,2,3,0,… and no requester is granted twice within any 4-cycle window.
- **Backpressure lock:**
  - Requester 1 is granted while `unit_ready_i=0` for 3 cycles and requester 0 raises valid meanwhile.
  - Required: `unit_tag_o` stays 1 and the payload stays stable until ready, then 1 issues. Requester 2 is granted next, ahead of 0, because the pointer is 2.
- **Outstanding limit:**
  - `MaxOutstanding=4` with responses withheld → exactly 4 issues, then `unit_valid_o=0`.
  - Releasing one response while requests are pending gives the next issue in the following cycle.
  - A same-cycle issue and response leaves `cnt_q` unchanged.
- **Flush:** 3 operations outstanding and a locked grant, then `flush_i` is pulsed with a coincident handshake → `flush_o=1`, `cnt_q=0`, lock cleared, `busy_o=0` the next cycle, and no grant in the flush cycle.
- **Response backpressure:** tag 3 is returned with `rsp_ready_i[3]=0` → `unit_rsp_ready_o=0` and `cnt_q` is held until `rsp_ready_i[3]=1`.

Source files
------------

// File: rtl/fpnew_sdotp_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// fpnew_sdotp_arbiter_pkg
//   Shared definitions for the dot-product unit arbiter slice.
//   Contents:
//     lock_state_e : grant-lock state (IDLE / LOCKED). While LOCKED, the
//                    arbiter holds the grant on a requester that the unit
//                    has not yet accepted.
// ----------------------------------------------------------------------------
package fpnew_sdotp_arbiter_pkg;

  typedef enum logic {
    LOCK_IDLE   = 1'b0,
    LOCK_LOCKED = 1'b1
  } lock_state_e;

endpackage

// File: rtl/fpnew_sdotp_rr_picker.sv
// ----------------------------------------------------------------------------
// fpnew_sdotp_rr_picker
//   Combinational rotate-priority picker. It returns the first set bit of
//   `valid`, searching upward from `ptr` and wrapping modulo NumReq.
//   Ports:
//     valid : per-requester valid vector
//     ptr   : index with the highest priority this cycle
//     idx   : winning index (0 when nothing is valid)
//     any   : at least one valid bit is set
// ----------------------------------------------------------------------------
module fpnew_sdotp_rr_picker #(
  parameter int NumReq   = 4,
  parameter int IdxWidth = $clog2(NumReq)
) (
  input  logic [NumReq-1:0]   valid,
  input  logic [IdxWidth-1:0] ptr,
  output logic [IdxWidth-1:0] idx,
  output logic                any
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the loop can leave it unassigned and infer a latch.
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      if (!any && valid[(int'(ptr) + i) % NumReq]) begin
        any = 1'b1;
        idx = IdxWidth'((int'(ptr) + i) % NumReq);
      end
    end
  end

endmodule

// File: rtl/fpnew_sdotp_arbiter.sv
// ----------------------------------------------------------------------------
// fpnew_sdotp_arbiter
//   Round-robin scheduler that shares one fpnew_sdotp_multi_wrapper among
//   NumReq requesters. It grants one request per cycle, tags the issued
//   operation with the requester index, caps the number of operations in
//   flight at MaxOutstanding, and routes each result back by tag.
//   Ports:
//     clk_i, rst_i          : clock, synchronous active-high reset
//     req_valid_i/ready_o   : per-requester issue handshake
//     req_i                 : per-requester payload (forwarded untouched)
//     unit_valid_o/ready_i  : issue handshake towards the unit
//     unit_req_o/tag_o      : granted payload and requester index
//     unit_rsp_valid_i/ready_o, unit_rsp_i, unit_rsp_tag_i : unit result
//     rsp_valid_o/ready_i   : per-requester response handshake
//     rsp_o                 : response payload, broadcast to all requesters
//     flush_i/flush_o       : kill in-flight work, forwarded to the unit
//     busy_o                : operations pending or issuing
//   Both the request path and the response path are purely combinational.
// ----------------------------------------------------------------------------
module fpnew_sdotp_arbiter
  import fpnew_sdotp_arbiter_pkg::*;
#(
  parameter int  NumReq         = 4,
  parameter int  MaxOutstanding = 4,
  parameter type ReqType        = logic,
  parameter type RspType        = logic,
  localparam int IdxWidth       = $clog2(NumReq)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  // requesters -> arbiter
  input  logic [NumReq-1:0]   req_valid_i,
  output logic [NumReq-1:0]   req_ready_o,
  input  ReqType              req_i [NumReq],
  // arbiter -> unit
  output logic                unit_valid_o,
  input  logic                unit_ready_i,
  output ReqType              unit_req_o,
  output logic [IdxWidth-1:0] unit_tag_o,
  // unit -> arbiter
  input  logic                unit_rsp_valid_i,
  output logic                unit_rsp_ready_o,
  input  RspType              unit_rsp_i,
  input  logic [IdxWidth-1:0] unit_rsp_tag_i,
  // arbiter -> requesters
  output logic [NumReq-1:0]   rsp_valid_o,
  input  logic [NumReq-1:0]   rsp_ready_i,
  output RspType              rsp_o,
  // control / status
  input  logic                flush_i,
  output logic                flush_o,
  output logic                busy_o
);

  localparam int CntWidth = $clog2(MaxOutstanding + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);

  lock_state_e         lock_state_q;
  logic                lock_q;
  logic [IdxWidth-1:0] lock_idx_q;
  logic [IdxWidth-1:0] ptr_q;
  logic [CntWidth-1:0] cnt_q;

  logic [IdxWidth-1:0] pick_idx;
  logic                pick_any;
  logic [IdxWidth-1:0] winner;
  logic                issue_hs;
  logic                rsp_hs;
  logic                rsp_dec;

  assign lock_q = (lock_state_q == LOCK_LOCKED);

  fpnew_sdotp_rr_picker #(
    .NumReq   (NumReq),
    .IdxWidth (IdxWidth)
  ) i_picker (
    .valid (req_valid_i),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // A stalled grant is pinned so the unit sees a stable payload and tag.
  assign winner = lock_q ? lock_idx_q : pick_idx;

  // The gate looks at the registered count only: a response arriving in the
  // same cycle frees a slot for the next cycle, not this one.
  assign unit_valid_o = pick_any && (cnt_q < CntMax) && !flush_i;
  assign unit_req_o   = req_i[winner];
  assign unit_tag_o   = winner;
  assign issue_hs     = unit_valid_o && unit_ready_i;

  always_comb begin
    req_ready_o = '0;
    if (issue_hs) req_ready_o[winner] = 1'b1;
  end

  // Response routing by tag.
  always_comb begin
    rsp_valid_o = '0;
    for (int t = 0; t < NumReq; t++) begin
      rsp_valid_o[t] = unit_rsp_valid_i && (unit_rsp_tag_i == IdxWidth'(t));
    end
  end

  assign unit_rsp_ready_o = rsp_ready_i[unit_rsp_tag_i];
  assign rsp_o            = unit_rsp_i;
  assign rsp_hs           = unit_rsp_valid_i && unit_rsp_ready_o;
  // Saturate at zero so a stray response cannot wrap the counter.
  assign rsp_dec          = rsp_hs && (cnt_q != '0);

  assign flush_o = flush_i;
  assign busy_o  = (cnt_q != '0) || unit_valid_o;

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst_i) begin
      lock_state_q <= LOCK_IDLE;
      lock_idx_q   <= '0;
      ptr_q        <= '0;
      cnt_q        <= '0;
    end else if (flush_i) begin
      // Handshakes in the flush cycle are discarded; the pointer holds.
      lock_state_q <= LOCK_IDLE;
      cnt_q        <= '0;
    end else begin
      unique case (lock_state_q)
        LOCK_IDLE: begin
          if (unit_valid_o && !unit_ready_i) begin
            lock_state_q <= LOCK_LOCKED;
            lock_idx_q   <= pick_idx;
          end
        end
        LOCK_LOCKED: begin
          if (issue_hs) lock_state_q <= LOCK_IDLE;
        end
        default: lock_state_q <= LOCK_IDLE;
      endcase

      if (issue_hs) begin
        ptr_q <= (winner == IdxWidth'(NumReq - 1)) ? '0 : winner + 1'b1;
      end

      if (issue_hs && !rsp_dec) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (!issue_hs && rsp_dec) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // A response with nothing outstanding is a protocol error by the unit.
  a_no_rsp_underflow : assert property (
    @(posedge clk_i) disable iff (rst_i)
    (rsp_hs && !flush_i) |-> (cnt_q != '0)
  );

endmodule

// File: tb/tb_fpnew_sdotp_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fpnew_sdotp_arbiter
//   Directed bench for fpnew_sdotp_arbiter with NumReq=4, MaxOutstanding=4.
//   Inputs change just after the falling edge; outputs are checked 1 ns later,
//   well away from the rising edge that commits state.
// ----------------------------------------------------------------------------
module tb_fpnew_sdotp_arbiter;

  localparam int NumReq = 4;
  localparam int MaxOut = 4;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NumReq-1:0] req_valid_i;
  logic [NumReq-1:0] req_ready_o;
  logic [15:0]       req_i [NumReq];
  logic              unit_valid_o;
  logic              unit_ready_i;
  logic [15:0]       unit_req_o;
  logic [1:0]        unit_tag_o;
  logic              unit_rsp_valid_i;
  logic              unit_rsp_ready_o;
  logic [15:0]       unit_rsp_i;
  logic [1:0]        unit_rsp_tag_i;
  logic [NumReq-1:0] rsp_valid_o;
  logic [NumReq-1:0] rsp_ready_i;
  logic [15:0]       rsp_o;
  logic              flush_i;
  logic              flush_o;
  logic              busy_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  fpnew_sdotp_arbiter #(
    .NumReq         (NumReq),
    .MaxOutstanding (MaxOut),
    .ReqType        (logic [15:0]),
    .RspType        (logic [15:0])
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_i            (req_i),
    .unit_valid_o     (unit_valid_o),
    .unit_ready_i     (unit_ready_i),
    .unit_req_o       (unit_req_o),
    .unit_tag_o       (unit_tag_o),
    .unit_rsp_valid_i (unit_rsp_valid_i),
    .unit_rsp_ready_o (unit_rsp_ready_o),
    .unit_rsp_i       (unit_rsp_i),
    .unit_rsp_tag_i   (unit_rsp_tag_i),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready_i),
    .rsp_o            (rsp_o),
    .flush_i          (flush_i),
    .flush_o          (flush_o),
    .busy_o           (busy_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    req_valid_i      = '0;
    unit_ready_i     = 1'b1;
    unit_rsp_valid_i = 1'b0;
    unit_rsp_tag_i   = '0;
    unit_rsp_i       = '0;
    rsp_ready_i      = '1;
    flush_i          = 1'b0;
  endtask

  // Advance to the next falling edge where new inputs are applied.
  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    step();
    idle_inputs();
    rst_i = 1'b1;
    @(posedge clk_i);
    @(posedge clk_i);
    step();
    rst_i = 1'b0;
    #1;
    check("rst_unit_valid", 32'(unit_valid_o), 32'd0);
    check("rst_req_ready",  32'(req_ready_o),  32'd0);
    check("rst_busy",       32'(busy_o),       32'd0);
    check("rst_cnt",        32'(dut.cnt_q),    32'd0);
    check("rst_ptr",        32'(dut.ptr_q),    32'd0);
  endtask

  initial begin
    for (int i = 0; i < NumReq; i++) req_i[i] = 16'hA000 + 16'(i);
    idle_inputs();
    rst_i = 1'b1;

    // ---------------- single request ----------------
    do_reset();
    step(); req_valid_i = 4'b0100; #1;
    check("single_valid", 32'(unit_valid_o), 32'd1);
    check("single_tag",   32'(unit_tag_o),   32'd2);
    check("single_ready", 32'(req_ready_o),  32'b0100);
    check("single_req",   32'(unit_req_o),   32'hA002);
    step(); req_valid_i = '0; #1;
    check("single_cnt1",  32'(dut.cnt_q),    32'd1);
    check("single_busy1", 32'(busy_o),       32'd1);
    step(); unit_rsp_valid_i = 1'b1; unit_rsp_tag_i = 2'd2; unit_rsp_i = 16'h5555; #1;
    check("single_rspv",  32'(rsp_valid_o),      32'b0100);
    check("single_rspr",  32'(unit_rsp_ready_o), 32'd1);
    check("single_rspd",  32'(rsp_o),            32'h5555);
    step(); unit_rsp_valid_i = 1'b0; #1;
    check("single_cnt0",  32'(dut.cnt_q), 32'd0);
    check("single_busy0", 32'(busy_o),    32'd0);

    // ---------------- fairness ----------------
    // Grant k goes to k%4; its response comes back 3 cycles later.
    do_reset();
    for (int k = 0; k < 12; k++) begin
      step();
      req_valid_i      = 4'b1111;
      unit_rsp_valid_i = (k >= 3);
      unit_rsp_tag_i   = 2'((k + 1) % 4);
      #1;
      check($sformatf("fair_tag%0d", k),   32'(unit_tag_o),  32'(k % 4));
      check($sformatf("fair_ready%0d", k), 32'(req_ready_o), 32'(1 << (k % 4)));
      check($sformatf("fair_cnt%0d", k),   32'(dut.cnt_q),   32'((k < 3) ? k : 3));
    end
    for (int k = 12; k < 15; k++) begin
      step();
      req_valid_i      = '0;
      unit_rsp_valid_i = 1'b1;
      unit_rsp_tag_i   = 2'((k + 1) % 4);
      #1;
      check($sformatf("fair_drain_rspv%0d", k), 32'(rsp_valid_o), 32'(1 << ((k + 1) % 4)));
    end
    step(); unit_rsp_valid_i = 1'b0; #1;
    check("fair_cnt_end", 32'(dut.cnt_q), 32'd0);

    // ---------------- backpressure lock ----------------
    // Pointer is 0 here. Requester 1 wins alone, then 0 and 2 join.
    step(); req_valid_i = 4'b0010; unit_ready_i = 1'b0; #1;
    check("lock_valid0", 32'(unit_valid_o), 32'd1);
    check("lock_tag0",   32'(unit_tag_o),   32'd1);
    check("lock_ready0", 32'(req_ready_o),  32'd0);
    for (int k = 1; k < 3; k++) begin
      step(); req_valid_i = 4'b0111; #1;
      check($sformatf("lock_tag%0d", k),  32'(unit_tag_o),  32'd1);
      check($sformatf("lock_req%0d", k),  32'(unit_req_o),  32'hA001);
      check($sformatf("lock_rdy%0d", k),  32'(req_ready_o), 32'd0);
    end
    step(); unit_ready_i = 1'b1; #1;
    check("lock_issue_tag", 32'(unit_tag_o),  32'd1);
    check("lock_issue_rdy", 32'(req_ready_o), 32'b0010);
    step(); req_valid_i = 4'b0101; #1;
    check("lock_next_tag", 32'(unit_tag_o),  32'd2);
    check("lock_next_rdy", 32'(req_ready_o), 32'b0100);
    step(); req_valid_i = 4'b0001; #1;
    check("lock_last_tag", 32'(unit_tag_o),  32'd0);

    // ---------------- flush ----------------
    // Three ops outstanding (1,2,0), pointer 1; lock requester 3.
    step(); req_valid_i = 4'b1000; unit_ready_i = 1'b0; #1;
    check("flush_pre_cnt", 32'(dut.cnt_q),   32'd3);
    check("flush_pre_tag", 32'(unit_tag_o),  32'd3);
    step(); #1;
    check("flush_pre_lock", 32'(dut.lock_q), 32'd1);
    step();
    flush_i = 1'b1; unit_ready_i = 1'b1;
    unit_rsp_valid_i = 1'b1; unit_rsp_tag_i = 2'd1;
    #1;
    check("flush_o",       32'(flush_o),      32'd1);
    check("flush_uvalid",  32'(unit_valid_o), 32'd0);
    check("flush_rdy",     32'(req_ready_o),  32'd0);
    step(); idle_inputs(); #1;
    check("flush_cnt",  32'(dut.cnt_q),  32'd0);
    check("flush_lock", 32'(dut.lock_q), 32'd0);
    check("flush_busy", 32'(busy_o),     32'd0);
    check("flush_ptr",  32'(dut.ptr_q),  32'd1);

    // ---------------- outstanding limit ----------------
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(); req_valid_i = 4'b1111; #1;
      check($sformatf("lim_tag%0d", k), 32'(unit_tag_o), 32'(k));
    end
    step(); #1;
    check("lim_full_valid", 32'(unit_valid_o), 32'd0);
    check("lim_full_rdy",   32'(req_ready_o),  32'd0);
    check("lim_full_cnt",   32'(dut.cnt_q),    32'd4);
    check("lim_full_busy",  32'(busy_o),       32'd1);
    step(); unit_rsp_valid_i = 1'b1; unit_rsp_tag_i = 2'd0; #1;
    check("lim_rsp_cycle_valid", 32'(unit_valid_o), 32'd0);
    // Slot freed: issue resumes; a coincident response keeps the count.
    step(); unit_rsp_tag_i = 2'd1; #1;
    check("lim_resume_valid", 32'(unit_valid_o), 32'd1);
    check("lim_resume_tag",   32'(unit_tag_o),   32'd0);
    check("lim_resume_cnt",   32'(dut.cnt_q),    32'd3);
    step(); unit_rsp_valid_i = 1'b0; #1;
    check("lim_same_cnt",   32'(dut.cnt_q),    32'd3);
    check("lim_same_tag",   32'(unit_tag_o),   32'd1);

    // ---------------- response backpressure ----------------
    // Outstanding now: 2,3,0,1 (count 4).
    step();
    req_valid_i = '0;
    unit_rsp_valid_i = 1'b1; unit_rsp_tag_i = 2'd3; rsp_ready_i = 4'b0111;
    #1;
    check("rbp_cnt4",  32'(dut.cnt_q),        32'd4);
    check("rbp_rspv",  32'(rsp_valid_o),      32'b1000);
    check("rbp_rdy0",  32'(unit_rsp_ready_o), 32'd0);
    step(); #1;
    check("rbp_hold",  32'(dut.cnt_q),        32'd4);
    rsp_ready_i = 4'b1111; #1;
    check("rbp_rdy1",  32'(unit_rsp_ready_o), 32'd1);
    step(); unit_rsp_valid_i = 1'b0; #1;
    check("rbp_cnt3",  32'(dut.cnt_q),        32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
